// File: rtl/control_pkg.sv
// Shared state encoding, opcode values, select encodings and the control bundle
// for the multicycle processor controller.
package control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_WB      = 4'd3,
        ST_MEM_RD  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_BRANCH  = 4'd6,
        ST_BR_TAKE = 4'd7,
        ST_JAL     = 4'd8,
        ST_JR      = 4'd9,
        ST_PUSH_SP = 4'd10,
        ST_PUSH_WR = 4'd11,
        ST_POP_RD  = 4'd12,
        ST_POP_SP  = 4'd13,
        ST_TRAP    = 4'd14,
        ST_HALT    = 4'd15
    } state_t;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_LW   = 4'h5,
        OP_SW   = 4'h6,
        OP_BR   = 4'h7,
        OP_JAL  = 4'h8,
        OP_JR   = 4'h9,
        OP_PUSH = 4'hA,
        OP_POP  = 4'hB,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {MEMSRC_PC = 2'd0, MEMSRC_SP_IMM = 2'd1, MEMSRC_SP = 2'd2} mem_src_e;
    typedef enum logic [2:0] {MEMDST_MARY = 3'd0, MEMDST_SHELLEY = 3'd1, MEMDST_RA = 3'd2,
                              MEMDST_COMP = 3'd3} mem_dst_e;
    typedef enum logic [2:0] {PCSRC_PLUS2 = 3'd0, PCSRC_IMM = 3'd1, PCSRC_RA = 3'd2,
                              PCSRC_BRANCH = 3'd3, PCSRC_TRAP = 3'd4} pc_src_e;
    typedef enum logic [2:0] {SPSRC_DEC = 3'd0, SPSRC_INC = 3'd1} sp_src_e;
    typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3} alu_op_e;
    typedef enum logic [1:0] {REGSRC_ALU = 2'd0, REGSRC_MEM = 2'd1, REGSRC_IMM = 2'd2} reg_src_e;
    typedef enum logic [1:0] {SRCB_SHELLEY = 2'd0, SRCB_IMM = 2'd1} src_b_e;

    typedef struct packed {
        logic       mem_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [2:0] sp_src;
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [1:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// Moore output map: (state, latched opcode) -> datapath control bundle.
module control_output_decode
    import control_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [OPC_W-1:0]   opcode,
    output ctrl_t              ctrl
);

    logic [3:0] alu_sel;
    logic [1:0] srcb_sel;

    always_comb begin
        ctrl     = '0;
        alu_sel  = ALU_ADD;
        srcb_sel = SRCB_SHELLEY;

        // ALU function for EXEC/WB; ADDI adds the zero-extended immediate
        case (opcode)
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            OP_ADDI: srcb_sel = SRCB_IMM;
            default: alu_sel = ALU_ADD;
        endcase

        case (state)
            ST_FETCH: begin
                ctrl.mem_src    = MEMSRC_PC;
                ctrl.inst_write = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_PLUS2;
            end
            ST_EXEC: begin
                ctrl.alu_op = alu_sel;
                ctrl.src_b  = srcb_sel;
            end
            ST_WB: begin
                ctrl.mary_write = 1'b1;
                ctrl.mary_src   = REGSRC_ALU;
                ctrl.alu_op     = alu_sel;
                ctrl.src_b      = srcb_sel;
            end
            ST_MEM_RD: begin
                ctrl.mem_src    = MEMSRC_SP_IMM;
                ctrl.mary_write = 1'b1;
                ctrl.mary_src   = REGSRC_MEM;
            end
            ST_MEM_WR: begin
                ctrl.mem_src   = MEMSRC_SP_IMM;
                ctrl.mem_dst   = MEMDST_MARY;
                ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.comp_write = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.src_b      = SRCB_SHELLEY;
            end
            ST_BR_TAKE: begin
                ctrl.pc_src   = PCSRC_BRANCH;
                ctrl.pc_write = 1'b1;
            end
            ST_JAL: begin
                ctrl.ra_write = 1'b1;
                ctrl.pc_src   = PCSRC_IMM;
                ctrl.pc_write = 1'b1;
            end
            ST_JR: begin
                ctrl.pc_src   = PCSRC_RA;
                ctrl.pc_write = 1'b1;
            end
            ST_PUSH_SP: begin
                ctrl.sp_src   = SPSRC_DEC;
                ctrl.sp_write = 1'b1;
            end
            ST_PUSH_WR: begin
                ctrl.mem_src   = MEMSRC_SP;
                ctrl.mem_dst   = MEMDST_MARY;
                ctrl.mem_write = 1'b1;
            end
            ST_POP_RD: begin
                ctrl.mem_src    = MEMSRC_SP;
                ctrl.mary_write = 1'b1;
                ctrl.mary_src   = REGSRC_MEM;
            end
            ST_POP_SP: begin
                ctrl.sp_src   = SPSRC_INC;
                ctrl.sp_write = 1'b1;
            end
            ST_TRAP: begin
                ctrl.pc_src   = PCSRC_TRAP;
                ctrl.pc_write = 1'b1;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: state register, opcode latch and sticky trap flag
// around the combinational output decoder.
module multicycle_control_unit
    import control_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        overflow,
    output logic        MemWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [2:0]  PCSrc,
    output logic [2:0]  SPSrc,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [1:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        SrcA,
    output logic [1:0]  SrcB,
    output logic [3:0]  AluOp,
    output logic        halted,
    output logic        trap_flag,
    output logic [3:0]  state_out
);

    state_t           state, next_state;
    logic [OPC_W-1:0] opcode_q;
    logic             trap_flag_q;
    ctrl_t            ctrl_raw, ctrl;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instruction[11:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_FETCH;
        else       state <= next_state;
    end

    // Opcode is captured in DECODE; the trap flag sets on leaving TRAP and sticks until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_q    <= '0;
            trap_flag_q <= 1'b0;
        end else begin
            if (state == ST_DECODE) opcode_q <= instruction[15:12];
            if (state == ST_TRAP)   trap_flag_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: begin
                case (instruction[15:12])
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: next_state = ST_EXEC;
                    OP_LW:   next_state = ST_MEM_RD;
                    OP_SW:   next_state = ST_MEM_WR;
                    OP_BR:   next_state = ST_BRANCH;
                    OP_JAL:  next_state = ST_JAL;
                    OP_JR:   next_state = ST_JR;
                    OP_PUSH: next_state = ST_PUSH_SP;
                    OP_POP:  next_state = ST_POP_RD;
                    OP_HALT: next_state = ST_HALT;
                    default: next_state = ST_TRAP;
                endcase
            end
            ST_EXEC: begin
                if (overflow && (opcode_q == OP_ADD || opcode_q == OP_SUB || opcode_q == OP_ADDI))
                    next_state = ST_TRAP;
                else
                    next_state = ST_WB;
            end
            ST_BRANCH:  next_state = ST_BR_TAKE;
            ST_PUSH_SP: next_state = ST_PUSH_WR;
            ST_POP_RD:  next_state = ST_POP_SP;
            ST_HALT:    next_state = ST_HALT;
            default:    next_state = ST_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .state  (state),
        .opcode (opcode_q),
        .ctrl   (ctrl_raw)
    );

    // Reset holds state at FETCH, so its enables must be masked while reset is high
    assign ctrl = reset ? '0 : ctrl_raw;

    assign MemWrite      = ctrl.mem_write;
    assign MemSrc        = ctrl.mem_src;
    assign MemDst        = ctrl.mem_dst;
    assign PCSrc         = ctrl.pc_src;
    assign SPSrc         = ctrl.sp_src;
    assign PCWrite       = ctrl.pc_write;
    assign SPWrite       = ctrl.sp_write;
    assign InstWrite     = ctrl.inst_write;
    assign mary_write    = ctrl.mary_write;
    assign shelley_write = ctrl.shelley_write;
    assign comp_write    = ctrl.comp_write;
    assign ra_write      = ctrl.ra_write;
    assign mary_src      = ctrl.mary_src;
    assign shelley_src   = ctrl.shelley_src;
    assign ra_src        = ctrl.ra_src;
    assign SrcA          = ctrl.src_a;
    assign SrcB          = ctrl.src_b;
    assign AluOp         = ctrl.alu_op;
    assign halted        = ctrl.halted;
    assign trap_flag     = trap_flag_q;
    assign state_out     = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction cycle model,
// directed vector table, random instruction stream and reset/trap/halt sequences.
module tb_multicycle_control_unit;
    import control_pkg::*;

    typedef struct packed {
        logic       mem_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [2:0] sp_src;
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [1:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       halted;
    } bund_t;

    typedef struct {
        logic [15:0] instr;
        logic        ovf;
        int          exp_cycles;
        logic        exp_trap;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        overflow = 1'b0;
    logic        MemWrite, PCWrite, SPWrite, InstWrite;
    logic        mary_write, shelley_write, comp_write, ra_write, ra_src, SrcA;
    logic        halted, trap_flag;
    logic [1:0]  MemSrc, mary_src, shelley_src, SrcB;
    logic [2:0]  MemDst, PCSrc, SPSrc;
    logic [3:0]  AluOp, state_out;
    bund_t       dut_b;

    int errors = 0;
    int checks = 0;
    logic sticky = 1'b0;
    vec_t tbl[12];

    always #5 clock = ~clock;

    multicycle_control_unit dut (
        .clock(clock), .reset(reset), .instruction(instruction), .overflow(overflow),
        .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
        .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
        .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
        .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
        .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .trap_flag(trap_flag),
        .state_out(state_out)
    );

    assign dut_b = {MemWrite, MemSrc, MemDst, PCSrc, SPSrc, PCWrite, SPWrite, InstWrite,
                    mary_write, shelley_write, comp_write, ra_write, mary_src, shelley_src,
                    ra_src, SrcA, SrcB, AluOp, halted};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic trapped(input logic [3:0] opc, input logic ovf);
        return ((opc == 4'h0 || opc == 4'h1 || opc == 4'h4) && ovf) ||
               (opc == 4'hC || opc == 4'hD || opc == 4'hE);
    endfunction

    function automatic int ncyc(input logic [3:0] opc, input logic ovf);
        if (opc <= 4'h4) return 4;
        if (opc == 4'h7 || opc == 4'hA || opc == 4'hB) return 4;
        if (trapped(opc, ovf)) return 3;
        return 3;
    endfunction

    function automatic bund_t trap_b();
        bund_t b = '0;
        b.pc_src = 3'd4; b.pc_write = 1'b1;
        return b;
    endfunction

    // Expected bundle for cycle c (0 = fetch) of an instruction with opcode opc
    function automatic bund_t model(input logic [3:0] opc, input logic ovf, input int c);
        bund_t b = '0;
        logic [3:0] alu;
        logic [1:0] sb;
        alu = (opc <= 4'h3) ? opc : 4'h0;
        sb  = (opc == 4'h4) ? 2'd1 : 2'd0;
        if (c == 0) begin
            b.inst_write = 1'b1; b.pc_write = 1'b1;
            return b;
        end
        if (c == 1) return b;
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                if (c == 2) begin
                    b.alu_op = alu; b.src_b = sb;
                end else if (c == 3) begin
                    if (trapped(opc, ovf)) b = trap_b();
                    else begin
                        b.mary_write = 1'b1; b.alu_op = alu; b.src_b = sb;
                    end
                end
            end
            4'h5: if (c == 2) begin b.mem_src = 2'd1; b.mary_write = 1'b1; b.mary_src = 2'd1; end
            4'h6: if (c == 2) begin b.mem_src = 2'd1; b.mem_write = 1'b1; end
            4'h7: begin
                if (c == 2) begin b.comp_write = 1'b1; b.alu_op = 4'd1; end
                if (c == 3) begin b.pc_src = 3'd3; b.pc_write = 1'b1; end
            end
            4'h8: if (c == 2) begin b.ra_write = 1'b1; b.pc_src = 3'd1; b.pc_write = 1'b1; end
            4'h9: if (c == 2) begin b.pc_src = 3'd2; b.pc_write = 1'b1; end
            4'hA: begin
                if (c == 2) begin b.sp_src = 3'd0; b.sp_write = 1'b1; end
                if (c == 3) begin b.mem_src = 2'd2; b.mem_write = 1'b1; end
            end
            4'hB: begin
                if (c == 2) begin b.mem_src = 2'd2; b.mary_write = 1'b1; b.mary_src = 2'd1; end
                if (c == 3) begin b.sp_src = 3'd1; b.sp_write = 1'b1; end
            end
            4'hF: b.halted = 1'b1;
            default: if (c == 2) b = trap_b();
        endcase
        return b;
    endfunction

    // Runs one instruction starting mid-FETCH; returns cycles until the next fetch
    task automatic run_instr(input logic [15:0] instr, input logic ovf, output int n);
        logic [3:0] opc;
        logic done;
        opc = instr[15:12];
        instruction = instr;
        overflow = ovf;
        done = 1'b0;
        n = 0;
        chk($sformatf("fetch_state op=%h", opc), 32'(state_out), 32'(ST_FETCH));
        chk($sformatf("trap_flag op=%h", opc), 32'(trap_flag), 32'(sticky));
        chk($sformatf("bundle op=%h cyc=0", opc), 32'(dut_b), 32'(model(opc, ovf, 0)));
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clock);
            if (InstWrite) begin
                n = k;
                done = 1'b1;
            end else begin
                chk($sformatf("bundle op=%h ovf=%0d cyc=%0d", opc, ovf, k),
                    32'(dut_b), 32'(model(opc, ovf, k)));
            end
        end
        if (!done) chk($sformatf("timeout op=%h", opc), 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        logic [3:0] opc;
        logic [15:0] ins;
        logic ov;

        tbl[0]  = '{16'h1000, 1'b0, 4, 1'b0};
        tbl[1]  = '{16'h5000, 1'b0, 3, 1'b0};
        tbl[2]  = '{16'h6000, 1'b0, 3, 1'b0};
        tbl[3]  = '{16'h2000, 1'b1, 4, 1'b0};
        tbl[4]  = '{16'h4028, 1'b1, 4, 1'b1};
        tbl[5]  = '{16'hA000, 1'b0, 4, 1'b0};
        tbl[6]  = '{16'h8044, 1'b0, 3, 1'b0};
        tbl[7]  = '{16'h9000, 1'b0, 3, 1'b0};
        tbl[8]  = '{16'h7000, 1'b0, 4, 1'b0};
        tbl[9]  = '{16'hB000, 1'b0, 4, 1'b0};
        tbl[10] = '{16'h3000, 1'b1, 4, 1'b0};
        tbl[11] = '{16'hD123, 1'b0, 3, 1'b1};

        // Reset state
        #1;
        chk("reset_state", 32'(state_out), 32'(ST_FETCH));
        chk("reset_bundle", 32'(dut_b), 32'd0);
        chk("reset_trap", 32'(trap_flag), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].instr, tbl[i].ovf, n);
            chk($sformatf("cycles vec%0d", i), 32'(n), 32'(tbl[i].exp_cycles));
            sticky = sticky | tbl[i].exp_trap;
        end

        for (int i = 0; i < 150; i++) begin
            opc = 4'($urandom_range(0, 14));
            ins = {opc, 12'($urandom)};
            ov  = 1'($urandom);
            run_instr(ins, ov, n);
            chk($sformatf("cycles rnd%0d op=%h", i, opc), 32'(n), 32'(ncyc(opc, ov)));
            sticky = sticky | trapped(opc, ov);
        end

        // Reset in the middle of EXEC aborts the instruction
        instruction = 16'h1000;
        overflow = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_exec_state", 32'(state_out), 32'(ST_EXEC));
        reset = 1'b1;
        #1;
        chk("rst_async_state", 32'(state_out), 32'(ST_FETCH));
        chk("rst_async_bundle", 32'(dut_b), 32'd0);
        chk("rst_async_trap", 32'(trap_flag), 32'd0);
        @(posedge clock);
        #1;
        chk("rst_held_bundle", 32'(dut_b), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sticky = 1'b0;
        #1;
        chk("post_rst_fetch", 32'(dut_b), 32'(model(4'h0, 1'b0, 0)));

        // Illegal opcode traps and sets the sticky flag
        instruction = 16'hC000;
        @(negedge clock);
        @(negedge clock);
        chk("illegal_trap_state", 32'(state_out), 32'(ST_TRAP));
        chk("illegal_trap_bundle", 32'(dut_b), 32'(trap_b()));
        @(negedge clock);
        chk("after_trap_state", 32'(state_out), 32'(ST_FETCH));
        chk("after_trap_flag", 32'(trap_flag), 32'd1);

        // HALT holds with only halted asserted
        instruction = 16'hF000;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_state%0d", i), 32'(state_out), 32'(ST_HALT));
            chk($sformatf("halt_bundle%0d", i), 32'(dut_b), 32'(model(4'hF, 1'b0, 2)));
            instruction = 16'($urandom);
            overflow = 1'($urandom);
            @(negedge clock);
        end
        chk("halt_trap_kept", 32'(trap_flag), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
